// File: rtl/sram_like_slave_pkg.sv
// rtl/sram_like_slave_pkg.sv - shared size encodings, head FSM states, request entry and byte-enable helper
package sram_like_slave_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wen;
   } req_t;

   localparam int REQ_W = $bits(req_t);

   // Low address bits beyond the size alignment are ignored rather than faulted.
   function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] be;
      case (size)
         SIZE_BYTE: be = 4'b0001 << addr_lo;
         SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
         default:   be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/sram_like_slave_if.sv
// rtl/sram_like_slave_if.sv - SRAM-like request/response bus plus the synchronous SRAM port
interface sram_like_slave_if;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata, sram_rdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output sram_en, sram_wen, sram_addr, sram_wdata
   );

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata, sram_rdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  sram_en, sram_wen, sram_addr, sram_wdata
   );
endinterface

// File: rtl/sram_like_req_fifo.sv
// rtl/sram_like_req_fifo.sv - synchronous request FIFO with full/empty flags and reset flush
module sram_like_req_fifo #(
   parameter int WIDTH = 71,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A full FIFO refuses pushes even in a cycle where it also pops.
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_like_slave.sv
// rtl/sram_like_slave.sv - SRAM-like responder: queues requests in order and runs each against a synchronous SRAM
module sram_like_slave
   import sram_like_slave_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int LATENCY    = 0
) (
   input logic              clk,
   input logic              rst,
   sram_like_slave_if.slave bus
);
   localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   state_t     state;
   state_t     state_next;
   logic [3:0] wait_cnt;
   logic [3:0] wait_next;
   logic       fifo_full;
   logic       fifo_empty;
   logic       push;
   logic       pop;
   req_t       push_req;
   req_t       head;
   logic       unused_head;

   assign bus.data_addr_ok = ~rst & ~fifo_full;
   assign push             = bus.data_req & bus.data_addr_ok;

   assign push_req = '{
      wr:    bus.data_wr,
      size:  bus.data_size,
      addr:  bus.data_addr,
      wdata: bus.data_wdata,
      wen:   byte_enables(bus.data_size, bus.data_addr[1:0])
   };

   // Size and low address bits are fully consumed by the enables computed at push.
   assign unused_head = ^{head.size, head.addr[1:0]};

   sram_like_req_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_req),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_next;
      end
   end

   // SRAM strobes decode the state register and the FIFO head only, so data_req never reaches them.
   always_comb begin
      state_next       = state;
      wait_next        = wait_cnt;
      pop              = 1'b0;
      bus.data_data_ok = 1'b0;
      bus.data_rdata   = '0;
      bus.sram_en      = 1'b0;
      bus.sram_wen     = '0;
      bus.sram_addr    = '0;
      bus.sram_wdata   = '0;
      case (state)
         ST_IDLE: begin
            // An entry being pushed this cycle counts, so an idle block issues on the next cycle.
            if (!fifo_empty || push) begin
               if (LATENCY > 0) begin
                  state_next = ST_WAIT;
                  wait_next  = LAT_LOAD;
               end else begin
                  state_next = ST_ISSUE;
               end
            end
         end
         ST_WAIT: begin
            if (wait_cnt == '0) begin
               state_next = ST_ISSUE;
            end else begin
               wait_next = wait_cnt - 4'd1;
            end
         end
         ST_ISSUE: begin
            bus.sram_en    = 1'b1;
            bus.sram_wen   = head.wr ? head.wen : 4'b0000;
            bus.sram_addr  = {head.addr[31:2], 2'b00};
            bus.sram_wdata = head.wdata;
            state_next     = ST_RESP;
         end
         ST_RESP: begin
            bus.data_data_ok = 1'b1;
            if (!head.wr) begin
               bus.data_rdata = bus.sram_rdata;
            end
            pop        = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sram_like_slave.sv
// tb/tb_sram_like_slave.sv - scoreboard bench over four responders with LATENCY 0, 1, 3 and 7
module tb_sram_like_slave;
   localparam int N_DUT = 4;

   typedef struct {
      bit          rd;
      logic [31:0] data;
      int          t_acc;
      int          lat;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  sel;
   int          cyc;

   logic [N_DUT-1:0] addr_ok_v;
   logic [N_DUT-1:0] data_ok_v;
   logic [N_DUT-1:0] sram_en_v;
   logic [31:0]      rdata_v      [N_DUT];
   logic [31:0]      sram_addr_v  [N_DUT];
   logic [31:0]      sram_wdata_v [N_DUT];
   logic [3:0]       sram_wen_v   [N_DUT];

   logic        addr_ok_s;
   logic        data_ok_s;
   logic        sram_en_s;
   logic [31:0] rdata_s;
   logic [31:0] sram_addr_s;
   logic [31:0] sram_wdata_s;
   logic [3:0]  sram_wen_s;

   logic [31:0] sb_mem [N_DUT][256];
   exp_t        sb_q[$];
   int          n_checks;
   int          n_errors;
   logic [3:0]  last_wen;
   logic [31:0] last_sram_addr;

   for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      sram_like_slave_if bus();
      logic [31:0] mem [256];

      sram_like_slave #(
         .FIFO_DEPTH (2),
         .LATENCY    ((g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 7)
      ) dut (
         .clk (clk),
         .rst (rst),
         .bus (bus.slave)
      );

      assign bus.data_req   = req & (sel == 2'(g));
      assign bus.data_wr    = wr;
      assign bus.data_size  = size;
      assign bus.data_addr  = addr;
      assign bus.data_wdata = wdata;

      assign addr_ok_v[g]    = bus.data_addr_ok;
      assign data_ok_v[g]    = bus.data_data_ok;
      assign sram_en_v[g]    = bus.sram_en;
      assign rdata_v[g]      = bus.data_rdata;
      assign sram_addr_v[g]  = bus.sram_addr;
      assign sram_wdata_v[g] = bus.sram_wdata;
      assign sram_wen_v[g]   = bus.sram_wen;

      initial begin
         for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      end

      always @(posedge clk) begin
         if (bus.sram_en) begin
            if (bus.sram_wen == 4'b0000) bus.sram_rdata <= mem[bus.sram_addr[9:2]];
            for (int b = 0; b < 4; b++) begin
               if (bus.sram_wen[b]) mem[bus.sram_addr[9:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
            end
         end
      end
   end

   always_comb begin
      addr_ok_s    = addr_ok_v[sel];
      data_ok_s    = data_ok_v[sel];
      sram_en_s    = sram_en_v[sel];
      rdata_s      = rdata_v[sel];
      sram_addr_s  = sram_addr_v[sel];
      sram_wdata_s = sram_wdata_v[sel];
      sram_wen_s   = sram_wen_v[sel];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] tb_be(input logic [1:0] sz, input logic [1:0] lo);
      logic [3:0] be;
      be = 4'b0000;
      if (sz == 2'b00) be[lo] = 1'b1;
      else if (sz == 2'b01) be = lo[1] ? 4'b1100 : 4'b0011;
      else be = 4'b1111;
      return be;
   endfunction

   task automatic model_accept(input logic w, input logic [1:0] sz, input logic [31:0] a,
                               input logic [31:0] wd, input int lat);
      exp_t       e;
      logic [3:0] be;
      int         wi;
      be      = tb_be(sz, a[1:0]);
      wi      = int'(a[9:2]);
      e.rd    = !w;
      e.t_acc = cyc;
      e.lat   = lat;
      if (w) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) sb_mem[sel][wi][8*b +: 8] = wd[8*b +: 8];
         end
         e.data = 32'h0;
      end else begin
         e.data = sb_mem[sel][wi];
      end
      sb_q.push_back(e);
   endtask

   // Called at a negedge; returns one negedge after the accepting edge with data_req low.
   task automatic send(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int lat);
      int budget;
      budget = 0;
      req = 1'b1; wr = w; size = sz; addr = a; wdata = wd;
      while (!addr_ok_s && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 200) begin
         check_eq("accept_timeout", 32'd0, 32'd1);
      end else begin
         model_accept(w, sz, a, wd, lat);
      end
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while (sb_q.size() != 0 && budget < 500) begin
         @(negedge clk);
         budget++;
      end
      check_eq("drain_outstanding", 32'(sb_q.size()), 32'd0);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sram_en_s) begin
         last_wen       = sram_wen_s;
         last_sram_addr = sram_addr_s;
      end
      if (data_ok_s) begin
         if (sb_q.size() == 0) begin
            check_eq("spurious_data_ok", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            check_eq(e.rd ? "rdata" : "wr_rdata", rdata_s, e.data);
            if (e.lat >= 0) check_eq("latency", 32'(cyc - e.t_acc), 32'(e.lat));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc [4];
      int budget;
      n_checks = 0;
      n_errors = 0;
      last_wen = 4'b0;
      last_sram_addr = 32'h0;
      for (int d = 0; d < N_DUT; d++) for (int i = 0; i < 256; i++) sb_mem[d][i] = 32'h0;
      rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b10; addr = 32'h0; wdata = 32'h0; sel = 2'd0;

      repeat (3) @(negedge clk);
      check_eq("rst_addr_ok", 32'(addr_ok_s), 32'd0);
      check_eq("rst_data_ok", 32'(data_ok_s), 32'd0);
      check_eq("rst_rdata", rdata_s, 32'h0);
      check_eq("rst_sram_en", 32'(sram_en_s), 32'd0);
      check_eq("rst_sram_wen", 32'(sram_wen_s), 32'd0);
      check_eq("rst_sram_addr", sram_addr_s, 32'h0);
      check_eq("rst_sram_wdata", sram_wdata_s, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_addr_ok", 32'(addr_ok_s), 32'd1);

      // Word write then read, LATENCY 0.
      sel = 2'd0;
      last_wen = 4'b0;
      send(1'b1, 2'b10, 32'h100, 32'hDEADBEEF, 2);
      drain();
      check_eq("word_wen", 32'(last_wen), 32'hF);
      send(1'b0, 2'b10, 32'h100, 32'h0, 2);
      drain();

      // Byte and half lanes.
      send(1'b1, 2'b10, 32'h200, 32'h11223344, -1);
      drain();
      send(1'b1, 2'b00, 32'h203, 32'h000000AA, 2);
      drain();
      check_eq("sb_wen", 32'(last_wen), 32'h8);
      send(1'b1, 2'b01, 32'h202, 32'h55550000, 2);
      drain();
      check_eq("sh_wen", 32'(last_wen), 32'hC);
      check_eq("sh_sram_addr", last_sram_addr, 32'h200);
      send(1'b0, 2'b10, 32'h200, 32'h0, 2);
      drain();

      // Overlap: request offered in the RESP cycle of the previous one.
      send(1'b0, 2'b10, 32'h100, 32'h0, 2);
      @(negedge clk);
      check_eq("ovl_data_ok", 32'(data_ok_s), 32'd1);
      check_eq("ovl_addr_ok", 32'(addr_ok_s), 32'd1);
      send(1'b0, 2'b10, 32'h200, 32'h0, 3);
      drain();

      // Back-pressure with LATENCY 3 and data_req held through four reads.
      sel = 2'd2;
      for (int i = 0; i < 4; i++) send(1'b1, 2'b10, 32'h300 + 32'(4 * i), 32'hA0A0_0000 + 32'(i), -1);
      drain();
      for (int i = 0; i < 4; i++) begin
         req = 1'b1; wr = 1'b0; size = 2'b10; addr = 32'h300 + 32'(4 * i);
         budget = 0;
         while (!addr_ok_s && budget < 100) begin
            @(negedge clk);
            budget++;
         end
         acc[i] = cyc;
         model_accept(1'b0, 2'b10, addr, 32'h0, -1);
         @(negedge clk);
      end
      req = 1'b0;
      check_eq("bp_second_accept", 32'(acc[1] - acc[0]), 32'd1);
      check_eq("bp_third_accept", 32'(acc[2] - acc[0]), 32'd6);
      check_eq("bp_fourth_accept", 32'(acc[3] - acc[0]), 32'd12);
      drain();

      // Reset with two requests outstanding.
      send(1'b0, 2'b10, 32'h300, 32'h0, -1);
      send(1'b0, 2'b10, 32'h304, 32'h0, -1);
      rst = 1'b1;
      #1;
      check_eq("midrst_addr_ok", 32'(addr_ok_s), 32'd0);
      @(negedge clk);
      check_eq("midrst_data_ok", 32'(data_ok_s), 32'd0);
      check_eq("midrst_sram_en", 32'(sram_en_s), 32'd0);
      check_eq("midrst_sram_wen", 32'(sram_wen_s), 32'd0);
      check_eq("midrst_sram_addr", sram_addr_s, 32'h0);
      check_eq("midrst_sram_wdata", sram_wdata_s, 32'h0);
      check_eq("midrst_rdata", rdata_s, 32'h0);
      sb_q.delete();
      rst = 1'b0;
      repeat (20) @(negedge clk);
      sel = 2'd0;
      send(1'b0, 2'b10, 32'h100, 32'h0, 2);
      drain();

      // Random ordered traffic at LATENCY 0, 1 and 7.
      for (int k = 0; k < 3; k++) begin
         sel = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : 2'd3;
         for (int n = 0; n < 40; n++) begin
            send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 32'($urandom_range(0, 255)), $urandom, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         drain();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
